param_shift_reg: RTL and testbench

Parametrised universal register, successor to the single-bit D flip-flop. It provides a WIDTH-bit storage register with hold, parallel load, logical shift, rotate and clear modes. It also drives true and complement outputs, serial outputs at both ends, and a saturating shift counter with a one-cycle done pulse. It is the common building block for serialisers, deserialisers and delay/rotate stages in the datapath.

---
 rtl/param_shift_reg_pkg.sv | 13 +
 rtl/param_shift_reg_sat_counter.sv | 45 ++++
 rtl/param_shift_reg.sv | 70 +++++++
 tb/tb_param_shift_reg.sv | 130 +++++++++++++
 4 files changed

// File: rtl/param_shift_reg_pkg.sv
// Shared definitions for the universal shift register: the mode encodings.
package psr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

endpackage

// File: rtl/param_shift_reg_sat_counter.sv
// Saturating up-counter with a one-cycle pulse on the edge that reaches MAX.
module sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         hit_q, hit_d;

    always_comb begin
        cnt_d = cnt_q;
        hit_d = 1'b0;
        if (en_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (inc_i && (cnt_q < W'(MAX))) begin
                cnt_d = cnt_q + W'(1);
                // Pulse only on the final step into saturation, never while parked there.
                hit_d = (cnt_q == W'(MAX - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign count_o = cnt_q;
    assign hit_o   = hit_q;

endmodule

// File: rtl/param_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear with a saturating
// shift counter and a done pulse after WIDTH shifts.
module param_shift_reg
    import psr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] q_outn,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             shift_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             is_shift, is_restart;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_LOAD:  q_d = d_in;
                MODE_SHL:   q_d = {q_q[WIDTH-2:0], ser_in_lsb};
                MODE_SHR:   q_d = {ser_in_msb, q_q[WIDTH-1:1]};
                MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_CLEAR: q_d = RESET_VAL;
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= RESET_VAL;
        else       q_q <= q_d;
    end

    assign is_shift   = (mode == MODE_SHL) || (mode == MODE_SHR) ||
                        (mode == MODE_ROL) || (mode == MODE_ROR);
    assign is_restart = (mode == MODE_LOAD) || (mode == MODE_CLEAR);

    sat_counter #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .inc_i   (is_shift),
        .clr_i   (is_restart),
        .count_o (shift_cnt),
        .hit_o   (shift_done)
    );

    assign q_out       = q_q;
    assign q_outn      = ~q_q;
    assign ser_out_msb = q_q[WIDTH-1];
    assign ser_out_lsb = q_q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg at WIDTH=8 with hand-computed expectations.
module tb_param_shift_reg;
    import psr_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, en, ser_in_lsb, ser_in_msb;
    logic [2:0]   mode;
    logic [W-1:0] d_in, q_out, q_outn;
    logic         ser_out_msb, ser_out_lsb, shift_done;
    logic [3:0]   shift_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_shift_reg #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .d_in        (d_in),
        .ser_in_lsb  (ser_in_lsb),
        .ser_in_msb  (ser_in_msb),
        .q_out       (q_out),
        .q_outn      (q_outn),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .shift_cnt   (shift_cnt),
        .shift_done  (shift_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic rst, input logic e, input logic [2:0] m,
                        input logic [W-1:0] d, input logic sl, input logic sm);
        reset = rst; en = e; mode = m; d_in = d; ser_in_lsb = sl; ser_in_msb = sm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = MODE_LOAD; d_in = 8'hA5;
        ser_in_lsb = 1'b0; ser_in_msb = 1'b0;

        // 1: reset overrides LOAD
        step(1, 1, MODE_LOAD, 8'hA5, 0, 0);
        step(1, 1, MODE_LOAD, 8'hA5, 0, 0);
        chk("rst_q", q_out, 8'h00);
        chk("rst_qn", q_outn, 8'hFF);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_done", shift_done, 0);

        // 2: load then SHL
        step(0, 1, MODE_LOAD, 8'hA5, 0, 0);
        chk("ld_q", q_out, 8'hA5);
        chk("ld_msb", ser_out_msb, 1);
        chk("ld_lsb", ser_out_lsb, 1);
        step(0, 1, MODE_SHL, 8'h00, 1, 0);
        chk("shl_q", q_out, 8'h4B);
        chk("shl_qn", q_outn, 8'hB4);
        chk("shl_cnt", shift_cnt, 1);

        // 3: rotates
        step(0, 1, MODE_LOAD, 8'h81, 0, 0);
        chk("ld81_cnt", shift_cnt, 0);
        step(0, 1, MODE_ROR, 8'h00, 0, 0);
        chk("ror_q", q_out, 8'hC0);
        chk("ror_cnt", shift_cnt, 1);
        step(0, 1, MODE_LOAD, 8'h81, 0, 0);
        step(0, 1, MODE_ROL, 8'h00, 0, 0);
        chk("rol_q", q_out, 8'h03);
        chk("rol_cnt", shift_cnt, 1);

        // 4: 9 SHR, done pulse on the 8th only
        step(0, 1, MODE_LOAD, 8'hA5, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, MODE_SHR, 8'h00, 0, 0);
            chk("shr_pre_done", shift_done, 0);
        end
        chk("shr7_cnt", shift_cnt, 7);
        step(0, 1, MODE_SHR, 8'h00, 0, 0);
        chk("shr8_q", q_out, 8'h00);
        chk("shr8_cnt", shift_cnt, 8);
        chk("shr8_done", shift_done, 1);
        step(0, 1, MODE_SHR, 8'h00, 0, 0);
        chk("shr9_cnt", shift_cnt, 8);
        chk("shr9_done", shift_done, 0);

        // 5: enable low and reserved mode both hold
        step(0, 1, MODE_LOAD, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, MODE_SHL, 8'hFF, 1, 1);
        chk("en0_q", q_out, 8'h3C);
        chk("en0_cnt", shift_cnt, 0);
        for (int i = 0; i < 2; i++) step(0, 1, MODE_RSVD, 8'hFF, 1, 1);
        chk("rsvd_q", q_out, 8'h3C);
        chk("rsvd_cnt", shift_cnt, 0);
        step(0, 1, MODE_CLEAR, 8'hFF, 0, 0);
        chk("clr_q", q_out, 8'h00);

        // 6: reset mid-sequence restarts the counter
        step(0, 1, MODE_LOAD, 8'hF0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, MODE_SHL, 8'h00, 0, 0);
        chk("pre_rst_q", q_out, 8'h00);
        chk("pre_rst_cnt", shift_cnt, 4);
        step(1, 1, MODE_SHL, 8'h00, 0, 0);
        chk("mid_rst_q", q_out, 8'h00);
        chk("mid_rst_cnt", shift_cnt, 0);
        for (int i = 0; i < 7; i++) step(0, 1, MODE_ROL, 8'h00, 0, 0);
        chk("post7_done", shift_done, 0);
        step(0, 1, MODE_ROL, 8'h00, 0, 0);
        chk("post8_done", shift_done, 1);
        chk("post8_cnt", shift_cnt, 8);
        step(0, 0, MODE_ROL, 8'h00, 0, 0);
        chk("post_en0_done", shift_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
